// File: rtl/mmu_banked.sv
// mmu_banked: CPU address decode into I/O, bank register and banked RAM,
// with I/O wait-state insertion and a boot-ROM-to-RAM copy after reset.
module mmu_banked #(
    parameter int unsigned ADDR_W        = 16,
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned BANK_W        = 2,
    parameter int unsigned IO_LIMIT      = 16'h0200,
    parameter int unsigned BANK_REG_ADDR = 16'h01FF,
    parameter int unsigned WIN_BASE      = 16'h8000,
    parameter int unsigned WIN_LOG2      = 13,
    parameter int unsigned IO_WAIT       = 1,
    parameter int unsigned BOOT_LEN      = 256,
    parameter int unsigned BOOT_BASE     = 16'hFF00
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_W-1:0]          addr,
    input  logic                       cpu_we,
    input  logic [DATA_W-1:0]          cpu_do,
    output logic [DATA_W-1:0]          cpu_di,
    output logic                       cpu_rdy,
    output logic [ADDR_W+BANK_W-1:0]   ram_addr,
    output logic                       ram_we,
    output logic [DATA_W-1:0]          ram_di,
    input  logic [DATA_W-1:0]          ram_do,
    output logic                       io_we,
    output logic [DATA_W-1:0]          io_di,
    input  logic [DATA_W-1:0]          io_do,
    output logic [((BOOT_LEN > 1) ? $clog2(BOOT_LEN) : 1)-1:0] boot_addr,
    input  logic [DATA_W-1:0]          boot_data,
    output logic                       boot_busy
);

    localparam int unsigned PA_W = ADDR_W + BANK_W;
    localparam int unsigned BA_W = (BOOT_LEN > 1) ? $clog2(BOOT_LEN) : 1;
    localparam int unsigned WC_W = (IO_WAIT > 1) ? $clog2(IO_WAIT) : 1;

    localparam logic [BA_W-1:0]   BOOT_LAST = BA_W'((BOOT_LEN > 0) ? BOOT_LEN - 1 : 0);
    localparam logic [WC_W-1:0]   WAIT_LOAD = WC_W'((IO_WAIT > 0) ? IO_WAIT - 1 : 0);
    localparam logic [ADDR_W-1:0] BANK_A    = ADDR_W'(BANK_REG_ADDR);
    localparam logic [ADDR_W-1:0] IO_LIM_A  = ADDR_W'(IO_LIMIT);
    localparam logic [ADDR_W-1:0] WIN_A     = ADDR_W'(WIN_BASE);
    localparam logic [ADDR_W-1:0] BOOT_A    = ADDR_W'(BOOT_BASE);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_BOOT,
        ST_RUN,
        ST_IOWAIT
    } state_t;

    state_t            state_reg;
    logic [BA_W-1:0]   boot_cnt_reg;
    logic [BANK_W-1:0] bank_reg;
    logic [WC_W-1:0]   wait_cnt_reg;

    logic              is_bank;
    logic              is_io;
    logic              in_win;
    logic              io_ready;
    logic [PA_W-1:0]   cpu_phys;
    logic [PA_W-1:0]   boot_phys;

    // The bank register sits inside I/O space but takes priority over it.
    assign is_bank = (addr == BANK_A);
    assign is_io   = !is_bank && (addr < IO_LIM_A);
    assign in_win  = (addr[ADDR_W-1:WIN_LOG2] == WIN_A[ADDR_W-1:WIN_LOG2]);

    assign cpu_phys  = in_win ? {bank_reg, addr} : {BANK_W'(0), addr};
    assign boot_phys = {BANK_W'(0), ADDR_W'(BOOT_A + ADDR_W'(boot_cnt_reg))};

    // In RUN an I/O access completes at once only when no wait states are set.
    assign io_ready = (state_reg == ST_IOWAIT) ? (wait_cnt_reg == '0) : (IO_WAIT == 0);

    assign boot_addr = boot_cnt_reg;
    assign boot_busy = (state_reg == ST_INIT) || (state_reg == ST_BOOT);
    assign io_di     = cpu_do;

    always_comb begin
        cpu_di   = '0;
        cpu_rdy  = 1'b0;
        ram_addr = cpu_phys;
        ram_we   = 1'b0;
        ram_di   = cpu_do;
        io_we    = 1'b0;
        case (state_reg)
            ST_INIT: begin
                ram_addr = boot_phys;
            end
            ST_BOOT: begin
                ram_addr = boot_phys;
                ram_di   = boot_data;
                ram_we   = 1'b1;
            end
            ST_RUN, ST_IOWAIT: begin
                if (is_bank) begin
                    cpu_rdy = 1'b1;
                    cpu_di  = DATA_W'(bank_reg);
                end else if (is_io) begin
                    cpu_rdy = io_ready;
                    cpu_di  = io_do;
                    io_we   = cpu_we & io_ready;
                end else begin
                    cpu_rdy = 1'b1;
                    cpu_di  = ram_do;
                    ram_we  = cpu_we;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_INIT;
            boot_cnt_reg <= '0;
            bank_reg     <= '0;
            wait_cnt_reg <= '0;
        end else begin
            case (state_reg)
                ST_INIT: begin
                    state_reg <= (BOOT_LEN == 0) ? ST_RUN : ST_BOOT;
                end
                ST_BOOT: begin
                    boot_cnt_reg <= boot_cnt_reg + BA_W'(1);
                    if (boot_cnt_reg == BOOT_LAST) begin
                        state_reg <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (is_bank) begin
                        if (cpu_we) begin
                            bank_reg <= cpu_do[BANK_W-1:0];
                        end
                    end else if (is_io && (IO_WAIT > 0)) begin
                        state_reg    <= ST_IOWAIT;
                        wait_cnt_reg <= WAIT_LOAD;
                    end
                end
                ST_IOWAIT: begin
                    // Always leave via RUN so a held address starts a fresh access.
                    if (wait_cnt_reg == '0) begin
                        state_reg <= ST_RUN;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - WC_W'(1);
                    end
                end
                default: state_reg <= ST_INIT;
            endcase
        end
    end

endmodule

// File: doc/mmu_banked.md
# mmu_banked

Parametrised memory-management unit between the 8-bit CPU core, the main RAM, the I/O space and the boot ROM. It decodes CPU addresses into I/O or RAM, and banks a configurable RAM window through a CPU-writable bank register. It inserts programmable wait states on I/O accesses, and it copies the boot image into RAM after reset while holding the CPU stalled.

## Interface
Parameters:
- ADDR_W, 16, CPU address width
- DATA_W, 8, data width
- BANK_W, 2, bank register width; physical RAM address width PA_W = ADDR_W+BANK_W
- IO_LIMIT, 16'h0200, CPU addresses below this are I/O space
- BANK_REG_ADDR, 16'h01FF, bank register address; must be < IO_LIMIT
- WIN_BASE, 16'h8000, base of the banked window; aligned to window size
- WIN_LOG2, 13, log2 of window size in bytes (8 KiB)
- IO_WAIT, 1, wait cycles per I/O access (0 allowed)
- BOOT_LEN, 256, bytes copied from boot ROM (0 allowed)
- BOOT_BASE, 16'hFF00, RAM address of first boot byte

Ports:
- clk  in  1  system clock; everything on rising edge
- rst  in  1  asynchronous, active-high reset
- addr  in  ADDR_W  CPU address
- cpu_we  in  1  CPU write strobe
- cpu_do  in  DATA_W  CPU write data
- cpu_di  out  DATA_W  CPU read data
- cpu_rdy  out  1  CPU may complete the current access; CPU holds addr/cpu_we/cpu_do while low
- ram_addr  out  PA_W  physical RAM address
- ram_we  out  1  RAM write enable
- ram_di  out  DATA_W  RAM write data
- ram_do  in  DATA_W  RAM read data (combinational)
- io_we  out  1  I/O write strobe
- io_di  out  DATA_W  I/O write data (= cpu_do)
- io_do  in  DATA_W  I/O read data (combinational)
- boot_addr  out  max(1,clog2(BOOT_LEN))  boot ROM address
- boot_data  in  DATA_W  boot ROM data (combinational on boot_addr)
- boot_busy  out  1  high until boot copy completes

## Operation
- FSM states are INIT, BOOT, RUN and IOWAIT. Reset forces INIT, boot counter 0, bank 0 and wait counter 0.
- INIT lasts one cycle. It goes to BOOT, or to RUN if BOOT_LEN==0. ram_we=0.
- BOOT:
  - boot_addr = counter; ram_addr = {0, BOOT_BASE+counter} (ADDR_W wrap); ram_di = boot_data; ram_we=1.
  - The counter increments each cycle. After writing byte BOOT_LEN-1 → RUN.
- Decode in RUN/IOWAIT, with priority:
  1. addr==BANK_REG_ADDR → bank register.
  2. addr<IO_LIMIT → I/O.
  3. Otherwise RAM.
- RAM address: if addr[ADDR_W-1:WIN_LOG2]==WIN_BASE[ADDR_W-1:WIN_LOG2], ram_addr = {bank, addr}; otherwise {BANK_W'b0, addr}.
- cpu_di:
  - RAM → ram_do.
  - I/O → io_do.
  - Bank register → zero-extended bank.
  - INIT/BOOT → 0.
- RAM write: ram_we = cpu_we & RAM region & cpu_rdy; ram_di = cpu_do.
- Bank write: when cpu_we & cpu_rdy at BANK_REG_ADDR, bank ← cpu_do[BANK_W-1:0] on the clock edge. No io_we and no wait states.
- I/O access in RUN, IO_WAIT>0:
  - cpu_rdy=0 and io_we=0. Next state IOWAIT with wait counter = IO_WAIT-1.
  - In IOWAIT, cpu_rdy = (counter==0). The counter decrements while nonzero.
  - When counter==0: io_we = cpu_we, then → RUN.
- I/O access with IO_WAIT==0: cpu_rdy=1 and io_we = cpu_we in RUN. No state change.
- io_we is asserted exactly one cycle per I/O write.
- boot_busy = (state is INIT or BOOT).

## Timing
- Values while rst is high or immediately after reset:
  - cpu_rdy=0, boot_busy=1, ram_we=0, io_we=0, boot_addr=0, cpu_di=0.
  - Bank is 0, so ram_addr upper bits are 0.
- Boot duration: 1 INIT cycle + BOOT_LEN BOOT cycles. cpu_rdy first goes high in the cycle RUN is entered, i.e. BOOT_LEN+1 cycles after reset release.
- RAM and bank-register accesses take one cycle (cpu_rdy=1, combinational data).
- I/O access takes IO_WAIT+1 cycles. Data is valid to the CPU in the cycle cpu_rdy=1.
- Back-to-back I/O accesses each incur the full IO_WAIT. Returning to RUN never re-completes the previous access.
- Bank write takes effect for accesses starting the cycle after the write edge.
- Reset asserted mid-BOOT restarts the copy from byte 0.
- Reset asserted mid-IOWAIT aborts the access with no io_we.
- CPU signals are ignored in INIT/BOOT: no io_we and no bank update.

## Test plan
- **Boot copy.** BOOT_LEN=4, ROM={11,22,33,44}, release rst. Required: RAM FF00..FF03 = 11,22,33,44; boot_busy low and cpu_rdy high at cycle 5; ram_we=0 during INIT.
- **Banked window.** Write 2 to 01FF, then write 5A to 8123. Required: ram_addr=0x28123. Reading 01FF returns 02. Writing to 4123 gives ram_addr=0x04123.
- **I/O wait states.** IO_WAIT=2, write 77 to 0010. Required: cpu_rdy=0,0,1; io_we high only in cycle 3, io_di=77. Read 0010 with io_do=3C gives cpu_di=3C in the cycle cpu_rdy=1.
- **Zero-wait I/O and back-to-back access.** IO_WAIT=0: io_we the same cycle. IO_WAIT=1: two consecutive I/O writes give exactly two io_we pulses over 4 cycles.
- **Reset mid-boot.** Assert rst at boot byte 2. Required: boot_addr=0 and boot_busy=1; after release the copy completes from byte 0.
- **Degenerate config.** BOOT_LEN=0 gives cpu_rdy=1 on the second cycle after reset release. A bank write attempted during BOOT leaves the bank at 0.
